alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_iter_unit.sv | 78 +++++++
 rtl/alu_multicycle.sv | 175 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Purpose: shared types and constants for the multicycle ALU (op codes, FSM states, flag bit positions).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

  // Operation select; values 10..15 are illegal and produce result 0, flags {0,1,0,1}.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } aluOp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } aluState_e;

  // Bit positions inside the 4-bit flags bus {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter_unit.sv
// Purpose: iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency: start strobe, then WIDTH iteration cycles; done is high during the last one.
// Backpressure: none; the caller owns sequencing and only pulses start when idle.
// Ports: clk, rst_n; start/isMul/a/b load a new operation; done strobes with the final
//        accumulator on lo/hi (MUL: product low/high, DIV/MOD: quotient/remainder).
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             isMul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] nextAcc;
  logic [WIDTH-1:0]   operand;   // multiplicand for MUL, divisor for DIV/MOD
  logic               mulMode;
  logic               running;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;

  // MUL: acc = {partial product, remaining multiplier bits}; add on LSB, shift right.
  // DIV: acc = {remainder, remaining dividend bits}; shift left, trial-subtract.
  // The shifted remainder can need WIDTH+1 bits, so the trial uses acc[2W-1:W-1].
  // A zero divisor never borrows: quotient becomes all ones and the remainder
  // ends up holding the dividend, which is exactly the required div-by-zero answer.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    remShift = acc[2*WIDTH-1:WIDTH-1];
    remDiff  = remShift - {1'b0, operand};
    if (mulMode)
      nextAcc = {mulSum, acc[WIDTH-1:1]};
    else if (remDiff[WIDTH])
      nextAcc = {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      nextAcc = {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      operand <= '0;
      mulMode <= 1'b0;
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      acc     <= isMul ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
      operand <= isMul ? a : b;
      mulMode <= isMul;
      running <= 1'b1;
      count   <= CW'(WIDTH);
    end else if (running) begin
      acc   <= nextAcc;
      count <= count - CW'(1);
      if (count == CW'(1))
        running <= 1'b0;
    end
  end

  // Final value is presented combinationally during the last iteration so the
  // caller can register it on the same edge and keep total latency at WIDTH+1.
  assign done = running && (count == CW'(1));
  assign lo   = nextAcc[WIDTH-1:0];
  assign hi   = nextAcc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_multicycle.sv
// Purpose: valid/ready ALU; single-cycle ops inline, MUL/DIV/MOD via alu_iter_unit.
// Latency: 1 cycle for ops 0-6 and illegal ops, WIDTH+1 cycles for MUL/DIV/MOD.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one request in flight.
// Ports: clk, rst_n; in_valid/in_ready/op/a/b request; out_valid/out_ready/result/flags
//        response ({N,Z,C,V}); busy high whenever the FSM is not IDLE.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam int SW  = $clog2(WIDTH);

  aluState_e        state, nextState;
  logic             accept;
  logic             isIterOp;
  logic             iterStart;
  logic             iterDone;
  logic [WIDTH-1:0] iterLo, iterHi;
  logic [3:0]       opReg;
  logic             bZero;

  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   addSum, subSum, shlWide, shrWide;
  logic [WIDTH-1:0] aluRes;
  logic             aluC, aluV;

  logic             capEn;
  logic [WIDTH-1:0] capRes;
  logic             capC, capV;
  logic [3:0]       capFlags;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign isIterOp  = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  assign iterStart = accept && isIterOp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // The DONE handoff returns to IDLE without peeking at in_valid, so an accept
  // can never coincide with a handoff.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = isIterOp ? ITER : DONE;
      ITER:    if (iterDone) nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Single-cycle datapath. Shifts are done one bit wider so the last bit shifted
  // out lands in the extra bit (and is 0 for a zero shift amount).
  assign shamt   = b[SW-1:0];
  assign addSum  = {1'b0, a} + {1'b0, b};
  assign subSum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shlWide = {1'b0, a} << shamt;
  assign shrWide = {a, 1'b0} >> shamt;

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (op)
      OP_ADD: begin
        aluRes = addSum[MSB:0];
        aluC   = addSum[WIDTH];
        aluV   = (a[MSB] == b[MSB]) && (addSum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        aluRes = subSum[MSB:0];
        aluC   = subSum[WIDTH];
        aluV   = (a[MSB] != b[MSB]) && (subSum[MSB] != a[MSB]);
      end
      OP_AND: aluRes = a & b;
      OP_OR:  aluRes = a | b;
      OP_XOR: aluRes = a ^ b;
      OP_SHL: begin
        aluRes = shlWide[MSB:0];
        aluC   = shlWide[WIDTH];
      end
      OP_SHR: begin
        aluRes = shrWide[WIDTH:1];
        aluC   = shrWide[0];
      end
      OP_MUL, OP_DIV, OP_MOD: ;  // produced by the iterative unit
      default: aluV = 1'b1;      // illegal op
    endcase
  end

  alu_iter_unit #(.WIDTH(WIDTH)) uIter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (iterStart),
    .isMul (op == OP_MUL),
    .a     (a),
    .b     (b),
    .done  (iterDone),
    .lo    (iterLo),
    .hi    (iterHi)
  );

  // Pick what gets registered into result/flags and when.
  always_comb begin
    capEn  = 1'b0;
    capRes = aluRes;
    capC   = aluC;
    capV   = aluV;
    if (accept && !isIterOp) begin
      capEn = 1'b1;
    end else if ((state == ITER) && iterDone) begin
      capEn  = 1'b1;
      capRes = (opReg == OP_MOD) ? iterLoHiSel(iterLo, iterHi, 1'b1) : iterLo;
      capC   = 1'b0;
      capV   = 1'b0;
      if (opReg == OP_MUL) begin
        capC = |iterHi;
        capV = |iterHi;
      end else if (bZero) begin
        capV = 1'b1;
      end
    end
    capFlags         = '0;
    capFlags[FLAG_N] = capRes[MSB];
    capFlags[FLAG_Z] = (capRes == '0);
    capFlags[FLAG_C] = capC;
    capFlags[FLAG_V] = capV;
  end

  function automatic logic [WIDTH-1:0] iterLoHiSel(input logic [WIDTH-1:0] l,
                                                   input logic [WIDTH-1:0] h,
                                                   input logic selHi);
    return selHi ? h : l;
  endfunction

  // Operands are captured inside the iter unit on accept; only op and the
  // zero-divisor condition are kept here, so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opReg  <= '0;
      bZero  <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      if (accept) begin
        opReg <= op;
        bZero <= (b == '0);
      end
      if (capEn) begin
        result <= capRes;
        flags  <= capFlags;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Purpose: randomized + directed scoreboard bench for alu_multicycle at WIDTH=8.
// Latency: checks 1-cycle and 9-cycle response latency per op class.
// Backpressure: drives random and held-low out_ready; checks DONE hold and in_ready timing.
module tb_alu_multicycle;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opI;
  logic [W-1:0] aI, bI;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (opI),
    .a         (aI),
    .b         (bI),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
    int         acc;
    int         op;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  bit   seenValid = 0;
  bit   bpRandom  = 0;
  int   cyc       = 0;
  int   nCmp      = 0;
  int   nFail     = 0;
  int   nIssued   = 0;
  int   nChecked  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bpRandom) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input longint act, input longint req);
    nCmp++;
    if (act != req) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the 8-bit op semantics.
  function automatic logic [11:0] refModel(input int op, input int a, input int b);
    int r, sa, sb, sh;
    bit c, v;
    logic [7:0] r8;
    c  = 0;
    v  = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    sh = b % 8;
    case (op)
      0: begin r = a + b; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin r = a - b; c = (a >= b);  v = (sa - sb > 127) || (sa - sb < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << sh; c = (sh != 0) ? (((a >> (8 - sh)) & 1) != 0) : 0; end
      6: begin r = a >> sh; c = (sh != 0) ? (((a >> (sh - 1)) & 1) != 0) : 0; end
      7: begin r = a * b; c = (r > 255); v = c; end
      8: if (b == 0) begin r = 255; v = 1; end else r = a / b;
      9: if (b == 0) begin r = a;   v = 1; end else r = a % b;
      default: begin r = 0; v = 1; end
    endcase
    r  = r & 255;
    r8 = r[7:0];
    return {r8, r8[7], (r8 == 8'h00), c, v};
  endfunction

  // Driver: waits for in_ready, presents one request for exactly one accept edge,
  // pushes its expected response, then scrambles the inputs.
  task automatic issue(input int op, input int a, input int b, input bit useExp,
                       input logic [7:0] eRes, input logic [3:0] eFlg);
    int n;
    logic [11:0] m;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    opI = op[3:0];
    aI  = a[7:0];
    bI  = b[7:0];
    m   = refModel(op, a, b);
    e.res = useExp ? eRes : m[11:4];
    e.flg = useExp ? eFlg : m[3:0];
    e.lat = (op >= 7 && op <= 9) ? W + 1 : 1;
    e.acc = cyc;
    e.op  = op;
    expQ.push_back(e);
    nIssued++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opI = 4'($urandom);
    aI  = 8'($urandom);
    bI  = 8'($urandom);
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("wait_out_valid_timeout", 0, 1);
  endtask

  // Monitor: pops on the first cycle a response is shown, re-checks it every
  // held cycle, and requires in_ready low while out_valid is high.
  always @(negedge clk) begin
    if (!rst_n) begin
      seenValid = 0;
    end else if (out_valid) begin
      if (!seenValid) begin
        if (expQ.size() == 0) begin
          nCmp++;
          nFail++;
          $display("FAIL unexpected_output: result 0x%0h flags %b with nothing pending", result, flags);
        end else begin
          cur = expQ.pop_front();
          nChecked++;
          check($sformatf("op%0d_result", cur.op), result, cur.res);
          check($sformatf("op%0d_flags", cur.op), flags, cur.flg);
          check($sformatf("op%0d_latency", cur.op), cyc - cur.acc, cur.lat);
        end
        seenValid = 1;
      end else begin
        check("hold_result", result, cur.res);
        check("hold_flags", flags, cur.flg);
      end
      check("in_ready_in_done", in_ready, 0);
      if (out_ready) seenValid = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit drop;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    opI = '0; aI = '0; bI = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);

    // Directed vectors with literal expectations.
    issue(0, 8'h7F, 8'h01, 1, 8'h80, 4'b1001);
    issue(1, 8'h05, 8'h05, 1, 8'h00, 4'b0110);
    issue(6, 8'h81, 8'h01, 1, 8'h40, 4'b0010);
    issue(7, 8'h10, 8'h20, 1, 8'h00, 4'b0111);
    drop = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!busy) drop = 1;
      if (out_valid) break;
      n++;
    end
    check("mul_busy_throughout", drop, 0);
    issue(8, 8'h64, 8'h07, 1, 8'h0E, 4'b0000);
    issue(9, 8'h64, 8'h07, 1, 8'h02, 4'b0000);
    issue(8, 8'h33, 8'h00, 1, 8'hFF, 4'b1001);
    issue(12, 8'h12, 8'h34, 1, 8'h00, 4'b0101);

    // Hold out_ready low in DONE, then release and watch in_ready.
    @(negedge clk);
    while (out_valid) @(negedge clk);
    out_ready = 1'b0;
    issue(4, 8'hA5, 8'h0F, 1, 8'hAA, 4'b1000);
    @(negedge clk);
    waitValid();
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_result", result, 8'hAA);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready_same_cycle", in_ready, 0);
    @(negedge clk);
    check("release_in_ready_next_cycle", in_ready, 1);
    check("release_out_valid_dropped", out_valid, 0);

    // Reset in the middle of a DIV iteration.
    issue(8, 8'hC8, 8'h03, 0, 8'h00, 4'h0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy_in_iter", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_result", result, 0);
    check("midreset_flags", flags, 0);
    expQ.delete();
    nIssued--;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_release_in_ready", in_ready, 1);
    drop = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) drop = 1;
    end
    check("no_stale_result", drop, 0);

    // Randomized traffic with random backpressure.
    bpRandom = 1;
    for (int i = 0; i < 150; i++) begin
      int ro, ra, rb;
      ro = $urandom_range(0, 15);
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      issue(ro, ra, rb, 0, 8'h00, 4'h0);
    end
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    bpRandom = 0;
    out_ready = 1'b1;
    check("drain_pending", expQ.size(), 0);
    check("all_responses_seen", nChecked, nIssued);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
